// File: rtl/cmp_flag_tally_if.sv
// Handshake bundle between the 2-bit comparator, cmp_flag_tally and the
// statistics consumer. The master modport is the side that feeds samples and
// takes records; the slave modport is the tally block itself.
interface cmp_flag_tally_if #(
  parameter int unsigned CNT_W = 8
);
  // Sample side
  logic             in_valid;
  logic             in_ready;
  logic             f1;
  logic             f2;
  logic             f3;
  logic             flush;
  // Record side
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_cnt1;
  logic [CNT_W-1:0] out_cnt2;
  logic [CNT_W-1:0] out_cnt3;
  logic [CNT_W-1:0] out_samples;
  logic             out_err;

  modport master (
    output in_valid, f1, f2, f3, flush, out_ready,
    input  in_ready, out_valid, out_cnt1, out_cnt2, out_cnt3, out_samples, out_err
  );

  modport slave (
    input  in_valid, f1, f2, f3, flush, out_ready,
    output in_ready, out_valid, out_cnt1, out_cnt2, out_cnt3, out_samples, out_err
  );
endinterface

// File: rtl/cmp_flag_tally.sv
// Tallies the comparator flags F1/F2/F3 over a window of WINDOW accepted
// samples (or a shorter window closed by flush) and reports one summary
// record over a valid/ready handshake.
// Optional feature macro: CMP_TALLY_CHECK_EN compiles in the F1 = NOR(F2, F3)
// consistency checker and its sticky error; without it out_err is tied to 0.
module cmp_flag_tally #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  cmp_flag_tally_if.slave      bus
);

  localparam logic [CNT_W-1:0] WinCnt = CNT_W'(WINDOW);

  typedef enum logic [0:0] {StAccum, StReport} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Running window counters
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic [CNT_W-1:0] cnt3_q, cnt3_d;

  // Record registers, held stable while the record is pending
  logic [CNT_W-1:0] out_samp_q;
  logic [CNT_W-1:0] out_cnt1_q;
  logic [CNT_W-1:0] out_cnt2_q;
  logic [CNT_W-1:0] out_cnt3_q;

  logic             accept;
  logic             close_win;

`ifdef CMP_TALLY_CHECK_EN
  logic             err_q, err_d;
  logic             out_err_q;
`endif

  // Counter updates including the sample accepted this cycle, and window-close decision
  always_comb begin
    accept    = (state_q == StAccum) & bus.in_valid;
    samp_d    = samp_q + CNT_W'(accept);
    cnt1_d    = cnt1_q + CNT_W'(accept & bus.f1);
    cnt2_d    = cnt2_q + CNT_W'(accept & bus.f2);
    cnt3_d    = cnt3_q + CNT_W'(accept & bus.f3);
`ifdef CMP_TALLY_CHECK_EN
    // A legal sample has f1 as the NOR of f2/f3, so equality flags a violation
    err_d     = err_q | (accept & (bus.f1 == (bus.f2 | bus.f3)));
`endif
    // Flush on an empty window (nothing accepted this cycle either) is dropped
    close_win = (state_q == StAccum) &
                ((accept & (samp_d == WinCnt)) | (bus.flush & (samp_d != '0)));
  end

  // Control FSM with registered handshake outputs and record capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      samp_q      <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      cnt3_q      <= '0;
      out_samp_q  <= '0;
      out_cnt1_q  <= '0;
      out_cnt2_q  <= '0;
      out_cnt3_q  <= '0;
`ifdef CMP_TALLY_CHECK_EN
      err_q       <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StAccum: begin
          if (close_win) begin
            out_samp_q  <= samp_d;
            out_cnt1_q  <= cnt1_d;
            out_cnt2_q  <= cnt2_d;
            out_cnt3_q  <= cnt3_d;
            samp_q      <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            cnt3_q      <= '0;
`ifdef CMP_TALLY_CHECK_EN
            out_err_q   <= err_d;
            err_q       <= 1'b0;
`endif
            state_q     <= StReport;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            samp_q      <= samp_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            cnt3_q      <= cnt3_d;
`ifdef CMP_TALLY_CHECK_EN
            err_q       <= err_d;
`endif
          end
        end
        StReport: begin
          // Flush and samples are ignored here; only the consumer releases us
          if (bus.out_ready) begin
            state_q     <= StAccum;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StAccum;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_samples = out_samp_q;
  assign bus.out_cnt1    = out_cnt1_q;
  assign bus.out_cnt2    = out_cnt2_q;
  assign bus.out_cnt3    = out_cnt3_q;
`ifdef CMP_TALLY_CHECK_EN
  assign bus.out_err     = out_err_q;
`else
  assign bus.out_err     = 1'b0;
`endif

  // Sample acceptance and record presentation never overlap
  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_q != out_valid_q);

  // A stalled record must not change under the consumer
  a_record_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_samp_q) &&
    $stable(out_cnt1_q) && $stable(out_cnt2_q) && $stable(out_cnt3_q)));

endmodule

// File: tb/tb_cmp_flag_tally.sv
// Bench for cmp_flag_tally: directed scenarios followed by random traffic.
// A window-level reference model queues expected records; a negedge monitor
// checks handshake outputs every cycle and record contents while valid.
module tb_cmp_flag_tally;

  localparam int unsigned CW  = 8;
  localparam int unsigned WIN = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_flag_tally_if #(.CNT_W(CW)) bus();

  cmp_flag_tally #(
    .CNT_W (CW),
    .WINDOW(WIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } smp_t;

  typedef struct {
    int n;
    int c1;
    int c2;
    int c3;
    int err;
  } rec_t;

  smp_t win[$];
  rec_t exp_q[$];
  bit   m_pending;
  int   total = 0;
  int   bad   = 0;
  int   recs_seen = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Summary of the current window computed straight from the sample list
  function automatic rec_t summarize();
    rec_t r;
    r.n = win.size();
    r.c1 = 0; r.c2 = 0; r.c3 = 0; r.err = 0;
    foreach (win[i]) begin
      r.c1 += int'(win[i].a);
      r.c2 += int'(win[i].b);
      r.c3 += int'(win[i].c);
`ifdef CMP_TALLY_CHECK_EN
      if (win[i].a == (win[i].b | win[i].c)) r.err = 1;
`endif
    end
    return r;
  endfunction

  // Reference model: collects accepted samples and closes windows
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.delete();
      exp_q.delete();
      m_pending <= 1'b0;
    end else if (!m_pending) begin
      if (bus.in_valid) win.push_back('{bus.f1, bus.f2, bus.f3});
      if ((bus.in_valid && win.size() == WIN) || (bus.flush && win.size() > 0)) begin
        exp_q.push_back(summarize());
        win.delete();
        m_pending <= 1'b1;
      end
    end else if (bus.out_ready) begin
      m_pending <= 1'b0;
    end
  end

  // Monitor: handshake state every cycle, record fields whenever presented
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", int'(bus.out_valid), 0);
    end else begin
      check("in_ready", int'(bus.in_ready), int'(!m_pending));
      check("out_valid", int'(bus.out_valid), int'(m_pending));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 1, 0);
        end else begin
          check("samples", int'(bus.out_samples), exp_q[0].n);
          check("cnt1", int'(bus.out_cnt1), exp_q[0].c1);
          check("cnt2", int'(bus.out_cnt2), exp_q[0].c2);
          check("cnt3", int'(bus.out_cnt3), exp_q[0].c3);
          check("err", int'(bus.out_err), exp_q[0].err);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            recs_seen++;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one sample (optionally with flush), waiting while the block is busy
  task automatic send(input logic a, input logic b, input logic c, input logic fl);
    int guard = 0;
    while (!bus.in_ready && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) check("send_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.f1 = a; bus.f2 = b; bus.f3 = c;
    bus.flush = fl;
    cycle();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.f1 = 1'b0; bus.f2 = 1'b0; bus.f3 = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    // Reset state
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_cnt1", int'(bus.out_cnt1), 0);
    check("rst_cnt2", int'(bus.out_cnt2), 0);
    check("rst_cnt3", int'(bus.out_cnt3), 0);
    check("rst_samples", int'(bus.out_samples), 0);
    check("rst_err", int'(bus.out_err), 0);

    // Full window of (1,0,0)
    for (int i = 0; i < int'(WIN); i++) send(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Alternating (0,1,0)/(0,0,1) with a 5-cycle consumer stall
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(WIN); i++) send(1'b0, i[0] ? 1'b0 : 1'b1, i[0], 1'b0);
    idle(5);
    bus.out_ready = 1'b1;
    idle(3);

    // Partial window closed by flush together with a sixth sample
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    pulse_flush();  // empty window: no record
    idle(3);

    // One inconsistent sample among fifteen legal ones, then a clean window
    for (int i = 0; i < int'(WIN); i++) begin
      if (i == 7) send(1'b1, 1'b1, 1'b0, 1'b0);
      else        send(i[0] ? 1'b1 : 1'b0, i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
    end
    idle(2);
    for (int i = 0; i < int'(WIN); i++) send(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset mid-window discards partial counts
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < int'(WIN); i++) send(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset while a record is pending drops out_valid without a clock edge
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b0, 1'b0);
    pulse_flush();
    idle(1);
    pulse_flush();  // flush in REPORT has no effect
    idle(1);
    check("pending_before_rst", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_ready", int'(bus.in_ready), 1);
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.f1        = 1'($urandom_range(0, 1));
      bus.f2        = 1'($urandom_range(0, 1));
      bus.f3        = 1'($urandom_range(0, 1));
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain any pending record within a bounded number of cycles
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && (m_pending || exp_q.size() != 0); i++) cycle();
    check("drain_left", exp_q.size(), 0);
    check("records_seen_min", int'(recs_seen >= 8), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
